writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//   Final pipeline stage of the RISC-V core; sits directly upstream of the register file.
//   Accepts retiring instructions from the execute/memory stage through a valid/ready handshake.
//   Waits for load data where needed, aligns and extends it, then selects the result.
//   Drives the register-file write port (RegWrite/rd/data) one cycle later; also counts retired instructions.
// PARAMETERS
//   INSTRET_W     64   width of retired-instruction counter; wraps modulo 2^INSTRET_W
//   LOAD_TIMEOUT  0    max cycles spent in WAIT_MEM before abort; 0 = no timeout
// PORTS
//   clk             in   1          clock
//   reset           in   1          synchronous, active-low reset
//   in_valid        in   1          upstream instruction valid
//   in_ready        out  1          stage can accept; combinational, = (state==IDLE)
//   in_reg_write    in   1          instruction writes rd
//   in_rd           in   5          destination register
//   in_wb_sel       in   2          result select: 0 ALU, 1 LOAD, 2 PC+4, 3 IMM (LUI)
//   in_alu_result   in   32         ALU result; also the load byte address
//   in_pc_plus4     in   32         PC+4, used by JAL/JALR
//   in_imm          in   32         U-type immediate
//   in_funct3       in   3          load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   mem_rvalid      in   1          load data valid; ignored unless state==WAIT_MEM
//   mem_rdata       in   32         raw aligned 32-bit word from data memory
//   wb_reg_write    out  1          register-file write enable, 1-cycle pulse
//   wb_rd           out  5          register-file write address
//   wb_data         out  32         register-file write data
//   retire_valid    out  1          1-cycle pulse per retired instruction
//   instret         out  INSTRET_W  retired-instruction count
//   load_err        out  1          1-cycle pulse: misaligned load or timeout
// BEHAVIOUR
//   Reset (reset==0 at a clk edge)
//     - state=IDLE; wb_reg_write, wb_rd, wb_data, retire_valid, load_err and instret all 0; timeout counter 0.
//     - Reset during WAIT_MEM abandons the load: no write, no retire, no err.
//   FSM states: IDLE, WAIT_MEM. Output registers are updated every cycle; pulse outputs default to 0.
//   IDLE, in_valid=1, in_wb_sel!=1
//     - Next edge: wb_data = ALU / PC+4 / IMM per sel; wb_rd = in_rd.
//     - Same edge: wb_reg_write = in_reg_write && in_rd!=0; retire_valid=1; instret+=1.
//     - Latency is 1 cycle; back-to-back acceptance every cycle.
//   IDLE, in_valid=1, in_wb_sel==1
//     - Capture rd, reg_write, funct3 and addr[1:0]; clear timeout counter; go to WAIT_MEM.
//     - in_ready=0 while in WAIT_MEM.
//   WAIT_MEM, mem_rvalid=1
//     - Next edge: write the extracted value; retire; go to IDLE. Write-enable rules as above.
//     - LB/LBU: byte addr*8, sign-/zero-extended.
//     - LH/LHU: halfword at addr[1]*16, sign-/zero-extended.
//     - LW: full word.
//   Misaligned load (LH/LHU with addr[0]=1, LW with addr[1:0]!=0)
//     - Still wait for mem_rvalid, then wb_reg_write=0, load_err=1, no retire, go to IDLE.
//   Reserved funct3 on a load: treated as LW.
//   Timeout (LOAD_TIMEOUT>0)
//     - Counter increments each WAIT_MEM cycle without mem_rvalid.
//     - When it reaches LOAD_TIMEOUT: load_err=1, no write, no retire, go to IDLE.
//     - mem_rvalid arriving in the same cycle as the timeout wins.
//   Other rules
//     - rd==0 never writes; wb_data still shows the computed value.
//     - instret wraps from all-ones to 0.
//     - in_valid while in_ready=0 is ignored; upstream holds its data.
// TESTING
//   1. Reset low 2 cycles then release -> all outputs 0, in_ready=1, instret=0.
//   2. ALU op rd=5, alu=0x1234, valid 1 cycle -> next cycle wb_reg_write=1, rd=5, data=0x1234, instret=1.
//   3. LB at addr=0x3; rvalid 3 cycles later with rdata=0x80FF_0000 -> in_ready=0 for 3 cycles;
//      then data=0xFFFF_FF80, written 1 cycle after rvalid.
//   4. LHU at addr=0x2 with rdata=0xBEEF_0001 -> data=0x0000_BEEF.
//      LW at addr=0x1 -> load_err=1, no write, instret unchanged.
//   5. JAL rd=0 with pc_plus4=0x104 -> wb_reg_write=0, wb_data=0x104, retire_valid=1.
//      Then 4 back-to-back ALU ops -> 4 consecutive write pulses.
//   6. LOAD_TIMEOUT=4, load with no rvalid -> load_err pulses after 4 WAIT_MEM cycles, then IDLE.
//      Separately, reset mid-WAIT_MEM -> no write, instret=0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Writeback stage bus: upstream instruction handshake, data-memory response and register-file write port.
// The master side is whoever feeds retiring instructions and load data; the slave side is the writeback stage.
// Everything except clock and reset travels through here.
interface writeback_stage_if #(
  parameter int INSTRET_W = 64
);
  // upstream instruction
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_reg_write;
  logic [4:0]           in_rd;
  logic [1:0]           in_wb_sel;
  logic [31:0]          in_alu_result;
  logic [31:0]          in_pc_plus4;
  logic [31:0]          in_imm;
  logic [2:0]           in_funct3;
  // data-memory response
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;
  // register-file write port and status
  logic                 wb_reg_write;
  logic [4:0]           wb_rd;
  logic [31:0]          wb_data;
  logic                 retire_valid;
  logic [INSTRET_W-1:0] instret;
  logic                 load_err;

  modport master (
    output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
           in_pc_plus4, in_imm, in_funct3, mem_rvalid, mem_rdata,
    input  in_ready, wb_reg_write, wb_rd, wb_data, retire_valid, instret, load_err
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
           in_pc_plus4, in_imm, in_funct3, mem_rvalid, mem_rdata,
    output in_ready, wb_reg_write, wb_rd, wb_data, retire_valid, instret, load_err
  );
endinterface

// File: rtl/writeback_stage.sv
// RISC-V writeback stage: selects ALU/PC+4/IMM or an aligned, extended load value and drives the register-file write port.
// Latency: 1 cycle for non-loads; loads retire 1 cycle after mem_rvalid.
// Backpressure: in_ready is low while a load waits for memory; a load may time out after LOAD_TIMEOUT wait cycles.
module writeback_stage #(
  parameter int INSTRET_W    = 64,
  parameter int LOAD_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  writeback_stage_if.slave bus
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t               state_q, state_d;
  logic [4:0]           ld_rd_q, ld_rd_d;
  logic                 ld_we_q, ld_we_d;
  logic [2:0]           ld_f3_q, ld_f3_d;
  logic [1:0]           ld_addr_q, ld_addr_d;
  logic [31:0]          tmo_cnt_q, tmo_cnt_d;
  logic                 wb_reg_write_q, wb_reg_write_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic                 retire_valid_q, retire_valid_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 load_err_q, load_err_d;

  logic [31:0]          ld_byte_word;
  logic [15:0]          ld_half;
  logic [31:0]          ld_value;
  logic                 ld_misaligned;

  // Extract and extend the addressed byte/halfword/word; reserved funct3 codes behave as LW.
  always_comb begin
    ld_byte_word  = bus.mem_rdata >> {ld_addr_q, 3'b000};
    ld_half       = ld_addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_value      = bus.mem_rdata;
    ld_misaligned = 1'b0;
    case (ld_f3_q)
      3'b000: ld_value = {{24{ld_byte_word[7]}}, ld_byte_word[7:0]};
      3'b100: ld_value = {24'h000000, ld_byte_word[7:0]};
      3'b001: begin
        ld_value      = {{16{ld_half[15]}}, ld_half};
        ld_misaligned = ld_addr_q[0];
      end
      3'b101: begin
        ld_value      = {16'h0000, ld_half};
        ld_misaligned = ld_addr_q[0];
      end
      default: begin
        ld_value      = bus.mem_rdata;
        ld_misaligned = |ld_addr_q;
      end
    endcase
  end

  // Next-state and next-output computation; pulses default low, data/rd hold until the next retire.
  always_comb begin
    state_d        = state_q;
    ld_rd_d        = ld_rd_q;
    ld_we_d        = ld_we_q;
    ld_f3_d        = ld_f3_q;
    ld_addr_d      = ld_addr_q;
    tmo_cnt_d      = tmo_cnt_q;
    wb_reg_write_d = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    retire_valid_d = 1'b0;
    instret_d      = instret_q;
    load_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_wb_sel == 2'd1) begin
            ld_rd_d   = bus.in_rd;
            ld_we_d   = bus.in_reg_write;
            ld_f3_d   = bus.in_funct3;
            ld_addr_d = bus.in_alu_result[1:0];
            tmo_cnt_d = 32'd0;
            state_d   = WAIT_MEM;
          end else begin
            case (bus.in_wb_sel)
              2'd2:    wb_data_d = bus.in_pc_plus4;
              2'd3:    wb_data_d = bus.in_imm;
              default: wb_data_d = bus.in_alu_result;
            endcase
            wb_rd_d        = bus.in_rd;
            wb_reg_write_d = bus.in_reg_write && (bus.in_rd != 5'd0);
            retire_valid_d = 1'b1;
            instret_d      = instret_q + INSTRET_W'(1);
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          // data arriving on the timeout cycle still completes the load
          state_d   = IDLE;
          wb_rd_d   = ld_rd_q;
          wb_data_d = ld_value;
          if (ld_misaligned) begin
            load_err_d = 1'b1;
          end else begin
            wb_reg_write_d = ld_we_q && (ld_rd_q != 5'd0);
            retire_valid_d = 1'b1;
            instret_d      = instret_q + INSTRET_W'(1);
          end
        end else if (LOAD_TIMEOUT > 0) begin
          if (tmo_cnt_q == 32'(LOAD_TIMEOUT - 1)) begin
            load_err_d = 1'b1;
            tmo_cnt_d  = 32'd0;
            state_d    = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      ld_rd_q        <= 5'd0;
      ld_we_q        <= 1'b0;
      ld_f3_q        <= 3'd0;
      ld_addr_q      <= 2'd0;
      tmo_cnt_q      <= 32'd0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'd0;
      retire_valid_q <= 1'b0;
      instret_q      <= '0;
      load_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ld_rd_q        <= ld_rd_d;
      ld_we_q        <= ld_we_d;
      ld_f3_q        <= ld_f3_d;
      ld_addr_q      <= ld_addr_d;
      tmo_cnt_q      <= tmo_cnt_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      retire_valid_q <= retire_valid_d;
      instret_q      <= instret_d;
      load_err_q     <= load_err_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.instret      = instret_q;
  assign bus.load_err     = load_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver predicts each result and its cycle, the monitor checks outputs.
// The reference model works from the instruction semantics (load size/extension/alignment, modular instret).
// A narrow instret exercises wrap-around; LOAD_TIMEOUT=4 exercises timeout and the same-cycle rvalid race.
`timescale 1ns/1ps
module tb_writeback_stage;
  localparam int IW = 6;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_if #(.INSTRET_W(IW)) bus();

  writeback_stage #(.INSTRET_W(IW), .LOAD_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          err;
    logic          wr;
    logic [4:0]    rd;
    logic [31:0]   data;
    logic [IW-1:0] ir;
    int            stamp;
  } exp_t;

  exp_t          q[$];
  logic [IW-1:0] m_instret = '0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Reference model for loads, from the ISA definition.
  function automatic int load_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit load_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (int'(a) % load_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    int sz;
    sz = load_size(f3);
    v  = w >> (8 * int'(a));
    if (sz == 1) v = v & 32'h0000_00FF;
    else if (sz == 2) v = v & 32'h0000_FFFF;
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // Monitor: every output pulse must match the oldest prediction, on the predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      while (q.size() > 0 && q[0].stamp < cyc) begin
        check("output_missing", 64'd0, 64'd1);
        void'(q.pop_front());
      end
      if (bus.retire_valid || bus.load_err || bus.wb_reg_write) begin
        if (q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("out_cycle", 64'(cyc), 64'(e.stamp));
          check("load_err", 64'(bus.load_err), 64'(e.err));
          check("retire_valid", 64'(bus.retire_valid), 64'(!e.err));
          check("wb_reg_write", 64'(bus.wb_reg_write), 64'(e.wr));
          check("instret", 64'(bus.instret), 64'(e.ir));
          if (!e.err) begin
            check("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
            check("wb_data", 64'(bus.wb_data), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic idle_cycle();
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid      = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.in_alu_result = $urandom;
    bus.mem_rdata     = $urandom;
    @(negedge clk);
  endtask

  // Issue one instruction at a negedge; for loads, respond after 'delay' empty wait cycles
  // (delay >= TO means memory never answers). Returns at a negedge with the stage idle.
  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [2:0] f3, input int delay, input logic [31:0] rdata);
    exp_t e;
    check("in_ready_issue", 64'(bus.in_ready), 64'd1);
    bus.in_valid      = 1'b1;
    bus.in_reg_write  = rw;
    bus.in_rd         = rd;
    bus.in_wb_sel     = sel;
    bus.in_alu_result = alu;
    bus.in_pc_plus4   = pc4;
    bus.in_imm        = imm;
    bus.in_funct3     = f3;
    bus.mem_rvalid    = 1'b0;
    if (sel != 2'd1) begin
      e.err   = 1'b0;
      e.wr    = rw && (rd != 5'd0);
      e.rd    = rd;
      e.data  = (sel == 2'd0) ? alu : (sel == 2'd2) ? pc4 : imm;
      m_instret = m_instret + 1'b1;
      e.ir    = m_instret;
      e.stamp = cyc + 1;
      q.push_back(e);
      @(negedge clk);
    end else begin
      @(negedge clk);
      for (int w = 1; w <= TO; w++) begin
        check("in_ready_wait", 64'(bus.in_ready), 64'd0);
        // stalled upstream traffic must be ignored
        bus.in_valid      = 1'($urandom_range(0, 1));
        bus.in_wb_sel     = 2'($urandom);
        bus.in_rd         = 5'($urandom);
        bus.in_alu_result = $urandom;
        if (w == delay + 1) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdata;
          e.rd    = rd;
          e.data  = load_val(f3, alu[1:0], rdata);
          e.stamp = cyc + 1;
          if (load_misaligned(f3, alu[1:0])) begin
            e.err = 1'b1;
            e.wr  = 1'b0;
          end else begin
            e.err = 1'b0;
            e.wr  = rw && (rd != 5'd0);
            m_instret = m_instret + 1'b1;
          end
          e.ir = m_instret;
          q.push_back(e);
          @(negedge clk);
          break;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        if (w == TO) begin
          e.err   = 1'b1;
          e.wr    = 1'b0;
          e.rd    = rd;
          e.data  = 32'd0;
          e.ir    = m_instret;
          e.stamp = cyc + 1;
          q.push_back(e);
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
    end
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_wb_reg_write", 64'(bus.wb_reg_write), 64'd0);
    check("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    check("rst_wb_data", 64'(bus.wb_data), 64'd0);
    check("rst_retire_valid", 64'(bus.retire_valid), 64'd0);
    check("rst_load_err", 64'(bus.load_err), 64'd0);
    check("rst_instret", 64'(bus.instret), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_reg_write = 1'b0; bus.in_rd = 5'd0; bus.in_wb_sel = 2'd0;
    bus.in_alu_result = 32'd0; bus.in_pc_plus4 = 32'd0; bus.in_imm = 32'd0; bus.in_funct3 = 3'd0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;

    // reset held low for two edges
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_reset_state();

    // ALU op, LB with sign extension (rvalid on the last pre-timeout cycle), LHU, misaligned LW
    issue(1'b1, 5'd5, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 3'd0, 0, 32'd0);
    issue(1'b1, 5'd7, 2'd1, 32'h0000_0003, 32'd0, 32'd0, 3'b000, 3, 32'h80FF_0000);
    issue(1'b1, 5'd8, 2'd1, 32'h0000_0002, 32'd0, 32'd0, 3'b101, 0, 32'hBEEF_0001);
    issue(1'b1, 5'd9, 2'd1, 32'h0000_0001, 32'd0, 32'd0, 3'b010, 1, 32'h1234_5678);

    // JAL to x0 then four back-to-back ALU writes
    issue(1'b1, 5'd0, 2'd2, 32'd0, 32'h0000_0104, 32'd0, 3'd0, 0, 32'd0);
    for (int i = 1; i <= 4; i++)
      issue(1'b1, 5'(i), 2'd0, 32'(i * 17), 32'd0, 32'd0, 3'd0, 0, 32'd0);

    // load that never gets data -> timeout
    issue(1'b1, 5'd3, 2'd1, 32'h0000_0000, 32'd0, 32'd0, 3'b010, TO, 32'd0);
    idle_cycle();
    idle_cycle();

    // reset while waiting on memory abandons the load
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_rd = 5'd4;
    bus.in_wb_sel = 2'd1; bus.in_funct3 = 3'b010; bus.in_alu_result = 32'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_instret = '0;
    check_reset_state();
    check("queue_empty_after_reset", 64'(q.size()), 64'd0);

    // randomized traffic; narrow instret wraps several times
    for (int n = 0; n < 300; n++) begin
      logic [1:0] sel;
      if ($urandom_range(0, 4) == 0) idle_cycle();
      sel = 2'($urandom);
      issue(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 31)), sel,
            $urandom, $urandom, $urandom, 3'($urandom),
            int'($urandom_range(0, TO)), $urandom);
    end

    repeat (3) idle_cycle();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
